// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/stall encodings,
// fetch FSM states and default cache geometry.
package inst_fetch_pkg;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b0;
  localparam logic        Stop      = 1'b1;
  localparam logic        NotStop   = 1'b0;

  localparam int ICACHE_ADDR_W  = 17;
  localparam int ICACHE_INDEX_W = 7;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_BUSY = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Byte-wide read port between the fetch stage (master) and the memory
// controller (slave).
interface inst_fetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [7:0]  mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_data
  );

endinterface

// File: rtl/inst_fetch_icache_dm.sv
// Direct-mapped instruction cache with one 32-bit word per line.
// Combinational read port, synchronous write port; only the valid bits reset.
module icache_dm
  import inst_fetch_pkg::*;
#(
  parameter  int ADDR_W  = ICACHE_ADDR_W,
  parameter  int INDEX_W = ICACHE_INDEX_W,
  localparam int TAG_W   = ADDR_W - INDEX_W - 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [INDEX_W-1:0] rd_index_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               rd_hit_o,
  output logic [31:0]        rd_data_o,
  input  logic               wr_en_i,
  input  logic [INDEX_W-1:0] wr_index_i,
  input  logic [TAG_W-1:0]   wr_tag_i,
  input  logic [31:0]        wr_data_i
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // Tag and data storage written on a line fill.
  // NOTE: the arrays carry no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk_in) begin
    if (wr_en_i) begin
      tag_mem[wr_index_i]  <= wr_tag_i;
      data_mem[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_hit_o  = valid_q[rd_index_i] && (tag_mem[rd_index_i] == rd_tag_i);
  assign rd_data_o = data_mem[rd_index_i];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, looks it up in the direct-mapped
// cache and, on a miss, assembles the word from four byte reads before
// filling the line. A redirect from EX aborts any fetch in progress.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ADDR_W  = ICACHE_ADDR_W,
  parameter int INDEX_W = ICACHE_INDEX_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [5:0]          stall,
  input  logic                branch_flag,
  input  logic [31:0]         branch_target,
  inst_fetch_if.master        mem,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_inst,
  output logic                stallreq_if
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   k_q, k_d;
  logic [23:0]  buf_q, buf_d;

  logic         cache_hit;
  logic [31:0]  cache_data;
  logic         cache_we;

  // Only stall[0] concerns the fetch stage; the upper bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  icache_dm #(
    .ADDR_W  (ADDR_W),
    .INDEX_W (INDEX_W)
  ) u_icache (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rd_index_i (pc_q[INDEX_W+1:2]),
    .rd_tag_i   (pc_q[ADDR_W-1:INDEX_W+2]),
    .rd_hit_o   (cache_hit),
    .rd_data_o  (cache_data),
    .wr_en_i    (cache_we),
    .wr_index_i (pc_q[INDEX_W+1:2]),
    .wr_tag_i   (pc_q[ADDR_W-1:INDEX_W+2]),
    .wr_data_i  ({mem.mem_data, buf_q})
  );

  // State register: PC, FSM state, byte counter and assembly buffer.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= FETCH_IDLE;
      pc_q    <= ZeroWord;
      k_q     <= 2'd0;
      buf_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state, memory request and IF/ID outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d      = state_q;
    pc_d         = pc_q;
    k_d          = k_q;
    buf_d        = buf_q;
    cache_we     = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_addr = ZeroWord;
    if_pc        = ZeroWord;
    if_inst      = ZeroWord;
    stallreq_if  = 1'b1;

    if (state_q == FETCH_IDLE && cache_hit) begin
      if_pc       = pc_q;
      if_inst     = cache_data;
      stallreq_if = 1'b0;
    end

    if (branch_flag) begin
      // The controller flushes IF/ID on a redirect, so no stall is needed.
      stallreq_if = 1'b0;
      pc_d        = branch_target & ~32'h3;
      state_d     = FETCH_IDLE;
      k_d         = 2'd0;
    end else begin
      unique case (state_q)
        FETCH_IDLE: begin
          if (cache_hit) begin
            if (stall[0] != Stop) pc_d = pc_q + 32'd4;
          end else begin
            state_d = FETCH_BUSY;
            k_d     = 2'd0;
          end
        end
        FETCH_BUSY: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = pc_q + {30'd0, k_q};
          if (mem.mem_valid) begin
            if (k_q == 2'd3) begin
              cache_we = 1'b1;
              k_d      = 2'd0;
              state_d  = FETCH_IDLE;
            end else begin
              case (k_q)
                2'd0:    buf_d[7:0]   = mem.mem_data;
                2'd1:    buf_d[15:8]  = mem.mem_data;
                default: buf_d[23:16] = mem.mem_data;
              endcase
              k_d = k_q + 2'd1;
            end
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end

    // Outputs are quiet while reset is held; this also drops mem_req at once.
    if (rst_in == RstEnable) begin
      cache_we     = 1'b0;
      mem.mem_req  = 1'b0;
      mem.mem_addr = ZeroWord;
      if_pc        = ZeroWord;
      if_inst      = ZeroWord;
      stallreq_if  = 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: byte-wide memory model, scoreboard of
// delivered (pc, inst) pairs, and directed checks for miss, redirect,
// collision, aliasing, wrap and asynchronous reset.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  logic        mem_ready;
  logic        force_valid;
  logic [11:0] force_addr;
  logic [11:0] rd_addr;
  logic [7:0]  tb_mem [4096];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb_q [$];
  exp_t mon_e;

  inst_fetch_if mem_bus ();

  // Memory model: answers while requested and ready; force_valid models a
  // controller whose response lands in the same cycle the request drops.
  assign rd_addr           = force_valid ? force_addr : mem_bus.mem_addr[11:0];
  assign mem_bus.mem_valid = (mem_bus.mem_req & mem_ready) | force_valid;
  assign mem_bus.mem_data  = mem_bus.mem_valid ? tb_mem[rd_addr] : 8'h00;

  always #5 clk_in = ~clk_in;

  inst_fetch dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .mem           (mem_bus),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .stallreq_if   (stallreq_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0];
    return {tb_mem[b + 12'd3], tb_mem[b + 12'd2], tb_mem[b + 12'd1], tb_mem[b]};
  endfunction

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc   = a;
    e.inst = word_at(a);
    sb_q.push_back(e);
  endtask

  // Scoreboard: a delivery is a cycle the IF/ID register actually accepts.
  always begin
    @(negedge clk_in);
    #3;
    if (rst_in && !stallreq_if && !branch_flag && !stall[0]) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pc", if_pc, mon_e.pc);
        check("sb_inst", if_inst, mon_e.inst);
      end
    end
  end

  // Serve one cache miss for word address a, then check the hit cycle.
  task automatic fetch_miss(input logic [31:0] a, input bit gaps);
    int k = 0;
    int cyc = 0;
    while (k < 4 && cyc < 60) begin
      @(negedge clk_in);
      mem_ready = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      #2;
      cyc++;
      if (mem_bus.mem_req) begin
        check("miss_addr", mem_bus.mem_addr, a + 32'(k));
        check("miss_stallreq", 32'(stallreq_if), 32'd1);
        if (mem_ready) k++;
      end else begin
        check("miss_idle_stallreq", 32'(stallreq_if), 32'd1);
        check("miss_idle_bubble", if_inst, 32'd0);
      end
    end
    check("miss_handshakes", 32'(k), 32'd4);
    @(negedge clk_in);
    mem_ready = 1'b0;
    #2;
    check("fill_hit_stallreq", 32'(stallreq_if), 32'd0);
    check("fill_hit_pc", if_pc, a);
  endtask

  task automatic redirect(input logic [31:0] t);
    @(negedge clk_in);
    branch_flag   = 1'b1;
    branch_target = t;
    mem_ready     = 1'b0;
    #2;
    check("redir_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("redir_stallreq", 32'(stallreq_if), 32'd0);
    @(posedge clk_in);
    #1;
    branch_flag = 1'b0;
  endtask

  task automatic hit_cycle(input logic [31:0] a);
    @(negedge clk_in);
    #2;
    check("stream_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("stream_stallreq", 32'(stallreq_if), 32'd0);
    check("stream_pc", if_pc, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in        = 1'b0;
    stall         = 6'd0;
    branch_flag   = 1'b0;
    branch_target = 32'd0;
    mem_ready     = 1'b0;
    force_valid   = 1'b0;
    force_addr    = 12'd0;
    for (int i = 0; i < 4096; i++) tb_mem[i] = 8'(i * 7 + 3);
    // Three-word loop: addi a0,x0,1 / addi a1,x0,2 / jal x0,-12
    tb_mem[0] = 8'h13; tb_mem[1]  = 8'h05; tb_mem[2]  = 8'h10; tb_mem[3]  = 8'h00;
    tb_mem[4] = 8'h93; tb_mem[5]  = 8'h05; tb_mem[6]  = 8'h20; tb_mem[7]  = 8'h00;
    tb_mem[8] = 8'h6f; tb_mem[9]  = 8'hf0; tb_mem[10] = 8'h5f; tb_mem[11] = 8'hff;

    // Reset state
    repeat (2) @(negedge clk_in);
    #2;
    check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_stallreq", 32'(stallreq_if), 32'd0);

    // Cold start
    @(negedge clk_in);
    rst_in = 1'b1;
    #2;
    check("cold_stallreq", 32'(stallreq_if), 32'd1);
    check("cold_mem_req", 32'(mem_bus.mem_req), 32'd0);
    push_exp(32'h0);
    fetch_miss(32'h0, 1'b0);
    check("cold_inst", if_inst, 32'h0010_0513);
    push_exp(32'h4);
    fetch_miss(32'h4, 1'b1);
    push_exp(32'h8);
    fetch_miss(32'h8, 1'b1);

    // Hit streaming: EX redirects back to 0 after each pass
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    push_exp(32'h0); push_exp(32'h4);
    redirect(32'h0);
    hit_cycle(32'h0); hit_cycle(32'h4); hit_cycle(32'h8);
    redirect(32'h0);
    hit_cycle(32'h0); hit_cycle(32'h4);

    // Stall hold at pc=0x8
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      stall = 6'b000001;
      #2;
      check("stall_pc", if_pc, 32'h8);
      check("stall_inst", if_inst, word_at(32'h8));
      check("stall_stallreq", 32'(stallreq_if), 32'd0);
    end
    push_exp(32'h8);
    @(negedge clk_in);
    stall = 6'd0;
    #2;
    check("stall_release_pc", if_pc, 32'h8);

    // Redirect mid-miss at k=2
    @(negedge clk_in);
    mem_ready = 1'b1;
    #2;
    check("adv_miss_stallreq", 32'(stallreq_if), 32'd1);
    @(negedge clk_in);
    #2;
    check("rmm_addr0", mem_bus.mem_addr, 32'hC);
    @(negedge clk_in);
    #2;
    check("rmm_addr1", mem_bus.mem_addr, 32'hD);
    @(negedge clk_in);
    branch_flag   = 1'b1;
    branch_target = 32'h103;
    #2;
    check("rmm_req", 32'(mem_bus.mem_req), 32'd0);
    check("rmm_stallreq", 32'(stallreq_if), 32'd0);
    @(posedge clk_in);
    #1;
    branch_flag = 1'b0;
    mem_ready   = 1'b0;
    push_exp(32'h100);
    fetch_miss(32'h100, 1'b1);

    // Last byte arrives in the same cycle as a redirect
    @(negedge clk_in);
    mem_ready = 1'b1;
    #2;
    check("col_idle_miss", 32'(stallreq_if), 32'd1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_in);
      #2;
      check("col_addr", mem_bus.mem_addr, 32'h104 + 32'(j));
    end
    @(negedge clk_in);
    mem_ready     = 1'b0;
    force_addr    = 12'h107;
    force_valid   = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h40;
    #2;
    check("col_req", 32'(mem_bus.mem_req), 32'd0);
    @(posedge clk_in);
    #1;
    force_valid = 1'b0;
    branch_flag = 1'b0;
    push_exp(32'h40);
    fetch_miss(32'h40, 1'b1);
    redirect(32'h104);
    push_exp(32'h104);
    fetch_miss(32'h104, 1'b0);
    redirect(32'hC);
    push_exp(32'hC);
    fetch_miss(32'hC, 1'b1);

    // Index alias: 0x200 evicts 0x0
    redirect(32'h0);
    push_exp(32'h0);
    @(negedge clk_in);
    #2;
    check("alias_base_hit", 32'(stallreq_if), 32'd0);
    redirect(32'h200);
    push_exp(32'h200);
    fetch_miss(32'h200, 1'b1);
    redirect(32'h0);
    push_exp(32'h0);
    fetch_miss(32'h0, 1'b1);

    // PC wrap from 0xFFFFFFFC to 0
    redirect(32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC);
    fetch_miss(32'hFFFF_FFFC, 1'b0);
    push_exp(32'h0);
    @(negedge clk_in);
    #2;
    check("wrap_pc", if_pc, 32'h0);
    check("wrap_stallreq", 32'(stallreq_if), 32'd0);

    // Reset asserted mid-FETCH clears the cache and drops mem_req at once
    redirect(32'h300);
    @(negedge clk_in);
    #2;
    check("rstf_idle_miss", 32'(stallreq_if), 32'd1);
    @(negedge clk_in);
    #2;
    check("rstf_req_before", 32'(mem_bus.mem_req), 32'd1);
    #1;
    rst_in = 1'b0;
    #1;
    check("rstf_req_async", 32'(mem_bus.mem_req), 32'd0);
    check("rstf_stallreq", 32'(stallreq_if), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    #2;
    check("rstf_cold_miss", 32'(stallreq_if), 32'd1);
    push_exp(32'h0);
    fetch_miss(32'h0, 1'b1);

    // Hold the next word so nothing further is delivered
    @(negedge clk_in);
    stall = 6'b000001;
    #2;
    check("final_hold_pc", if_pc, 32'h0);
    check("final_hold_stallreq", 32'(stallreq_if), 32'd1);
    repeat (2) @(negedge clk_in);
    #4;
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; it produces the (pc, inst) pair that the IF/ID pipeline register samples.
- A 4-byte instruction is assembled from a byte-wide memory read port, with a direct-mapped instruction cache in front of it.
- On a cache miss it raises a stall request to the pipeline controller and fetches the word byte by byte.
- PC redirects from EX abort any fetch in progress.

Parameters:
ADDR_W, 17, physical byte-address bits used for memory and for the cache tag.
INDEX_W, 7, cache index bits (2^INDEX_W one-word lines).
(Derived: TAG_W = ADDR_W - INDEX_W - 2.)

Ports:
clk_in  input  1  clock; all state changes on the rising edge.
rst_in  input  1  reset, asynchronous, active-low.
stall  input  6  pipeline stall vector from the controller; stall[0]=1 freezes the PC.
branch_flag  input  1  redirect request from EX.
branch_target  input  32  redirect PC.
mem_req  output  1  byte read request to the memory controller.
mem_addr  output  32  byte address of the request.
mem_valid  input  1  requested byte is present on mem_data this cycle.
mem_data  input  8  returned byte.
if_pc  output  32  PC of the delivered instruction (to IF/ID).
if_inst  output  32  delivered instruction (to IF/ID).
stallreq_if  output  1  request to the controller to stall IF and insert a bubble.

Behaviour:
- States: IDLE, FETCH. Byte counter k is 2 bits. Assembly buffer buf is 24 bits (bytes 0..2).
- Reset (rst_in=0, asynchronous) puts the block in this state:
  - pc=0, state=IDLE, k=0, buf=0.
  - All cache valid bits cleared.
  - Outputs: mem_req=0, mem_addr=0, if_pc=0, if_inst=0, stallreq_if=0.
- Lookup uses index=pc[INDEX_W+1:2] and tag=pc[ADDR_W-1:INDEX_W+2]. Hit = valid[index] && tag matches.
- Outputs are combinational:
  - In IDLE on a hit: if_pc=pc, if_inst=line data, stallreq_if=0.
  - Otherwise: if_pc=0, if_inst=0 (bubble) and stallreq_if=1.
  - Exception: when branch_flag=1, stallreq_if=0, because the controller flushes that cycle anyway.
- IDLE, hit, stall[0]=0: pc<=pc+4 at the clock edge. Zero-cycle fetch latency.
- IDLE, hit, stall[0]=1: pc holds and the outputs stay stable.
- IDLE, miss: go to FETCH with k=0, regardless of stall[0].
- FETCH:
  - Drives mem_req=1 and mem_addr=pc+k.
  - On mem_valid with k<3: byte k goes into buf[8k+7:8k], then k<=k+1.
  - On mem_valid with k=3: the line is written as {mem_data, buf}, little-endian, with valid=1 and the tag set. Then k<=0 and state<=IDLE.
  - The next cycle therefore hits. A miss costs 4 memory handshakes plus one cycle.
  - mem_req stays high between bytes. mem_addr changes only on a cycle after mem_valid.
- Memory controller contract: mem_valid is asserted only while mem_req=1. Dropping mem_req cancels the outstanding read.
- branch_flag=1 has the highest priority over hit, fetch progress and stall:
  - pc<=branch_target with bits [1:0] forced to 0.
  - state<=IDLE, k<=0, mem_req=0 in that cycle.
  - Partial bytes are discarded and no cache write happens, even if mem_valid with k=3 arrives in the same cycle.
- PC arithmetic is 32-bit and wraps from 0xFFFFFFFC to 0. Memory/cache addressing ignores bits [31:ADDR_W].
- The cache is never invalidated except by reset; self-modifying code is not supported.
- Reset asserted mid-FETCH: mem_req drops asynchronously and no partial line is written.

Decomposition:
- Shared defines package gets:
  - ZeroWord, RstEnable for active-low (1'b0), Stop/NotStop.
  - Fetch state encodings FETCH_IDLE and FETCH_BUSY.
  - ICACHE_INDEX_W and ICACHE_ADDR_W defaults.
- One sub-module, icache_dm, is natural:
  - Tag/data/valid arrays, combinational read port (hit, data) and synchronous write port.
  - Valid bits clear on rst_in.
- The inst_fetch top holds the PC, the FSM and byte assembly.

Test Plan:
- Cold start: release reset; memory at 0x0..0x3 = 13 05 10 00. Required: stallreq_if=1, mem_addr steps 0,1,2,3. The cycle after the 4th mem_valid gives if_pc=0x0, if_inst=0x00100513, stallreq_if=0, and pc becomes 0x4 on the following edge.
- Hit streaming: loop of 3 words, second pass. Required: if_pc 0x0,0x4,0x8,0x0,... one per cycle, mem_req=0 throughout.
- Stall hold: hit at pc=0x8 with stall[0]=1 for 3 cycles. Required: if_pc=0x8 and if_inst unchanged for all 3 cycles, pc advances to 0xC only after stall[0] drops.
- Redirect mid-miss: in FETCH at k=2, pulse branch_flag with branch_target=0x103. Required: mem_req=0 in that cycle, next mem_addr=0x100, and the line for the old pc is still a miss later.
- Branch plus last byte collision: mem_valid with k=3 in the same cycle as branch_flag (target 0x40). Required: no cache write (re-fetching the old pc misses), pc=0x40.
- Index alias: fetch 0x0, then 0x200 (same index for INDEX_W=7), then 0x0. Required: the third access misses and re-fetches 4 bytes.
